// File: rtl/stream_demux4_pkg.sv
// Shared types and constants for the stream_demux4 slice.
//   NUM_LANES      number of output lanes
//   lane_sel_t     2-bit lane index
//   demux_state_t  packet-tracking state of the demux
package stream_demux4_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } demux_state_t;

endpackage

// File: rtl/stream_demux4_if.sv
// Bundle of the stream_demux4 handshake and status signals.
//   in_valid/in_ready/in_data/in_sel/in_last : producer-side stream
//   out_valid/out_ready/out_data/out_last    : four consumer lanes, lane i at bit i / slice i
//   busy, pkt_cnt                            : status
// Modports:
//   slave  : the demux itself
//   master : the environment (producer plus the four consumers)
interface stream_demux4_if
  import stream_demux4_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_data;
  lane_sel_t                     in_sel;
  logic                          in_last;
  logic [NUM_LANES-1:0]          out_valid;
  logic [NUM_LANES-1:0]          out_ready;
  logic [NUM_LANES*DATA_W-1:0]   out_data;
  logic [NUM_LANES-1:0]          out_last;
  logic                          busy;
  logic [NUM_LANES*CNT_W-1:0]    pkt_cnt;

  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, pkt_cnt
  );

  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, pkt_cnt
  );

endinterface

// File: rtl/stream_demux4_lane.sv
// One-deep valid/ready register slice for a single demux output lane.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   load_i       an accepted input beat targets this lane
//   data_i       beat payload
//   last_i       beat is the final one of its packet
//   ready_i      downstream ready
//   valid_o      slice holds a beat
//   data_o       held payload
//   last_o       held last flag
module demux_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  // A load always wins over a drain, so a simultaneous load and drain keeps
  // valid high with the new beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/stream_demux4.sv
// 1-to-4 packet demultiplexer. The destination lane is taken from in_sel on
// a packet's first beat and locked until the last beat is accepted. Each
// lane sits behind a one-deep register slice (demux_lane).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : stream_demux4_if.slave (input stream, four output lanes,
//                busy, per-lane completed-packet counters)
// Build option:
//   STREAM_DEMUX4_PKT_CNT_EN  when defined, pkt_cnt counts completed packets
//                             per lane (wrapping); otherwise pkt_cnt is 0.
//
// state | meaning
// IDLE  | between packets; the lane follows in_sel
// BUSY  | inside a multi-beat packet; the lane is the locked sel_q
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  stream_demux4_if.slave  bus
);

  demux_state_t state_q, state_d;
  lane_sel_t    sel_q, sel_d;
  lane_sel_t    sel_eff;
  logic         in_ready;
  logic         accept;

  logic [NUM_LANES-1:0]        lane_load;
  logic [NUM_LANES-1:0]        lane_valid;
  logic [NUM_LANES-1:0]        lane_last;
  logic [DATA_W-1:0]           lane_data [NUM_LANES];
  logic [NUM_LANES*DATA_W-1:0] out_data_w;

  assign sel_eff  = (state_q == BUSY) ? sel_q : bus.in_sel;
  // Only the selected lane can stall the producer.
  assign in_ready = !lane_valid[sel_eff] || bus.out_ready[sel_eff];
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (accept) begin
      if (state_q == IDLE && !bus.in_last) begin
        state_d = BUSY;
        sel_d   = bus.in_sel;
      end else if (state_q == BUSY && bus.in_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_load[i] = accept && (sel_eff == lane_sel_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_lane #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load_i  (lane_load[g]),
      .data_i  (bus.in_data),
      .last_i  (bus.in_last),
      .ready_i (bus.out_ready[g]),
      .valid_o (lane_valid[g]),
      .data_o  (lane_data[g]),
      .last_o  (lane_last[g])
    );
  end

  always_comb begin
    out_data_w = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      out_data_w[i*DATA_W +: DATA_W] = lane_data[i];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = lane_valid;
  assign bus.out_data  = out_data_w;
  assign bus.out_last  = lane_last;
  assign bus.busy      = (state_q == BUSY);

`ifdef STREAM_DEMUX4_PKT_CNT_EN
  logic [CNT_W-1:0]           cnt_q [NUM_LANES];
  logic [NUM_LANES*CNT_W-1:0] cnt_w;

  // A packet is complete when its last beat leaves the lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_valid[i] && bus.out_ready[i] && lane_last[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_w = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cnt_w[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign bus.pkt_cnt = cnt_w;
`else
  assign bus.pkt_cnt = '0;
`endif

endmodule
